// File: rtl/key_repeat_pkg.sv
// key_repeat_pkg
//   Shared types and defaults for the key auto-repeat block and its users.
//   - key_rep_state_t : arbitration/repeat state (IDLE, DELAY, REPEAT)
//   - DEF_* constants : default key count, countdown width and tick timings
package key_repeat_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } key_rep_state_t;

    localparam int unsigned DEF_N_KEYS       = 4;
    localparam int unsigned DEF_CNT_W        = 8;
    localparam logic [7:0]  DEF_DELAY_TICKS  = 8'd50;
    localparam logic [7:0]  DEF_REPEAT_TICKS = 8'd10;

endpackage

// File: rtl/key_repeat_if.sv
// key_repeat_if
//   Groups the key-repeat signals between the button front end and game logic.
//   tick    : one-cycle timing enable from the clock divider
//   keys_in : debounced button levels, 1 = pressed
//   act     : one-hot one-cycle pulse, press or repeat of the owner key
//   rel     : one-hot one-cycle pulse, owner key released
//   owner   : one-hot level, key currently owning the block (0 when idle)
//   Modports: master drives tick/keys_in, slave (the key_repeat block) drives
//   act/rel/owner.
interface key_repeat_if
    import key_repeat_pkg::*;
#(
    parameter int unsigned N_KEYS = DEF_N_KEYS
);

    logic              tick;
    logic [N_KEYS-1:0] keys_in;
    logic [N_KEYS-1:0] act;
    logic [N_KEYS-1:0] rel;
    logic [N_KEYS-1:0] owner;

    modport master (
        output tick,
        output keys_in,
        input  act,
        input  rel,
        input  owner
    );

    modport slave (
        input  tick,
        input  keys_in,
        output act,
        output rel,
        output owner
    );

endinterface

// File: rtl/key_repeat_tick_countdown.sv
// tick_countdown
//   Loadable down-counter advanced by a tick enable; general-purpose game timer.
//   clk, rst_n  : clock, asynchronous active-low reset (count clears to 0)
//   i_load      : load i_load_val (takes priority over i_tick)
//   i_load_val  : value to load; 0 gives a timer that never fires
//   i_tick      : count enable
//   o_fire      : combinational, high when a tick arrives with count == 1
//   After firing without a reload the count rests at 0 (one-shot).
module tick_countdown #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_tick,
    output logic             o_fire
);

    logic [CNT_W-1:0] r_cnt;

    assign o_fire = i_tick & (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/key_repeat.sv
// key_repeat
//   Converts debounced button levels into one-cycle action pulses: one on
//   press, then typematic repeats while held. One key owns the block at a
//   time; the lowest-index newly pressed key wins. Timing counts ticks.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   kif   : key_repeat_if.slave (tick, keys_in in; act, rel, owner out)
//   DELAY_TICKS = 0 disables auto-repeat; REPEAT_TICKS must be >= 1.
module key_repeat
    import key_repeat_pkg::*;
#(
    parameter int unsigned      N_KEYS       = DEF_N_KEYS,
    parameter int unsigned      CNT_W        = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DELAY_TICKS  = CNT_W'(DEF_DELAY_TICKS),
    parameter logic [CNT_W-1:0] REPEAT_TICKS = CNT_W'(DEF_REPEAT_TICKS)
) (
    input  logic        clk,
    input  logic        rst_n,
    key_repeat_if.slave kif
);

    key_rep_state_t    r_state, w_state_nxt;
    logic [N_KEYS-1:0] r_last;
    logic [N_KEYS-1:0] r_owner, w_owner_nxt;
    logic [N_KEYS-1:0] r_act, w_act_nxt;
    logic [N_KEYS-1:0] r_rel, w_rel_nxt;
    logic [N_KEYS-1:0] w_rise;
    logic [N_KEYS-1:0] w_pick;
    logic              w_held;
    logic              w_load;
    logic [CNT_W-1:0]  w_load_val;
    logic              w_cnt_tick;
    logic              w_fire;

    assign w_rise = kif.keys_in & ~r_last;
    // Isolate the lowest set bit (x & -x): lowest-index priority.
    assign w_pick = w_rise & (~w_rise + N_KEYS'(1));
    assign w_held = |(kif.keys_in & r_owner);
    // Count only while an owner is held, so a release cycle never fires.
    assign w_cnt_tick = kif.tick & w_held & (r_state != IDLE);

    tick_countdown #(
        .CNT_W (CNT_W)
    ) u_countdown (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_tick     (w_cnt_tick),
        .o_fire     (w_fire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_act_nxt   = '0;
        w_rel_nxt   = '0;
        w_load      = 1'b0;
        w_load_val  = REPEAT_TICKS;
        case (r_state)
            IDLE: begin
                if (|w_rise) begin
                    w_state_nxt = DELAY;
                    w_owner_nxt = w_pick;
                    w_act_nxt   = w_pick;
                    w_load      = 1'b1;
                    w_load_val  = DELAY_TICKS;
                end
            end
            DELAY, REPEAT: begin
                if (!w_held) begin
                    w_state_nxt = IDLE;
                    w_owner_nxt = '0;
                    w_rel_nxt   = r_owner;
                end else if (w_fire) begin
                    w_state_nxt = REPEAT;
                    w_act_nxt   = r_owner;
                    w_load      = 1'b1;
                    w_load_val  = REPEAT_TICKS;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_owner_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= '1;
            r_owner <= '0;
            r_act   <= '0;
            r_rel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= kif.keys_in;
            r_owner <= w_owner_nxt;
            r_act   <= w_act_nxt;
            r_rel   <= w_rel_nxt;
        end
    end

    assign kif.act   = r_act;
    assign kif.rel   = r_rel;
    assign kif.owner = r_owner;

endmodule
